// File: rtl/post_mem_pkg.sv
// Shared opcodes, FSM states and default response bytes for the Post CPU memory host.
package post_mem_pkg;

    // Host command opcodes (upper nibble of the command byte)
    localparam logic [3:0] CMD_NOP      = 4'h0;
    localparam logic [3:0] CMD_SET_ADDR = 4'h1;
    localparam logic [3:0] CMD_WR_CODE  = 4'h2;
    localparam logic [3:0] CMD_WR_DATA  = 4'h3;
    localparam logic [3:0] CMD_RD_DATA  = 4'h4;
    localparam logic [3:0] CMD_RD_CODE  = 4'h5;
    localparam logic [3:0] CMD_RUN      = 4'h6;

    localparam logic [7:0] DONE_BYTE_DEF = 8'hA5;
    localparam logic [7:0] TMO_BYTE_DEF  = 8'hEE;

    typedef enum logic [2:0] {
        StIdle,
        StGetAddr,
        StRunPulse,
        StWaitStart,
        StWaitStop,
        StAbort
    } state_e;

endpackage

// File: rtl/post_dual_ram.sv
// Storage array with one clocked write port and two combinational read ports.
module post_dual_ram #(
    parameter int unsigned Width = 4,
    parameter int unsigned AddrW = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AddrW-1:0] waddr,
    input  logic [Width-1:0] wdata,
    input  logic [AddrW-1:0] raddr_a,
    output logic [Width-1:0] rdata_a,
    input  logic [AddrW-1:0] raddr_b,
    output logic [Width-1:0] rdata_b
);

    logic [Width-1:0] mem [2**AddrW];

    // Contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/post_mem_host.sv
// Code/tape memory for the Post CPU plus a byte-stream host loader and run supervisor.
module post_mem_host
    import post_mem_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned CODE_W      = 4,
    parameter int unsigned TIMEOUT_CYC = 65535,
    parameter logic [7:0]  DONE_BYTE   = DONE_BYTE_DEF,
    parameter logic [7:0]  TMO_BYTE    = TMO_BYTE_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_byte,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              cpu_run,
    output logic              cpu_reset,
    input  logic [7:0]        cpu_state,
    input  logic [ADDR_W-1:0] cpu_code_add,
    output logic [CODE_W-1:0] cpu_code,
    input  logic [ADDR_W-1:0] cpu_data_add,
    output logic              cpu_din,
    input  logic              cpu_dout,
    input  logic              cpu_data_we
);

    localparam logic [31:0] TmoLast = 32'(TIMEOUT_CYC) - 32'd1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [31:0]       timer_q, timer_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_byte_q, out_byte_d;

    logic              accept;
    logic [3:0]        opcode;
    logic              cpu_owns;
    logic              timeout;
    logic              code_we;
    logic              host_data_we;
    logic              data_we;
    logic [ADDR_W-1:0] data_waddr;
    logic              data_wdata;
    logic [CODE_W-1:0] host_code;
    logic              host_data;

    // Gating with reset_n keeps in_ready low while reset is held
    assign in_ready = reset_n && !out_valid_q
                      && (state_q == StIdle || state_q == StGetAddr);
    assign accept   = in_valid && in_ready;
    assign opcode   = in_byte[7:4];
    assign cpu_owns = (state_q == StRunPulse) || (state_q == StWaitStart)
                      || (state_q == StWaitStop) || (state_q == StAbort);
    assign timeout  = (TIMEOUT_CYC != 0) && (timer_q == TmoLast);

    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;
    assign cpu_run   = (state_q == StRunPulse);
    assign cpu_reset = (state_q == StAbort);

    // Tape write port belongs to the CPU only while a run is in progress
    assign data_we    = cpu_owns ? cpu_data_we  : host_data_we;
    assign data_waddr = cpu_owns ? cpu_data_add : ptr_q;
    assign data_wdata = cpu_owns ? cpu_dout     : in_byte[0];

    post_dual_ram #(
        .Width (CODE_W),
        .AddrW (ADDR_W)
    ) u_code_ram (
        .clk     (clk),
        .we      (code_we),
        .waddr   (ptr_q),
        .wdata   (in_byte[CODE_W-1:0]),
        .raddr_a (cpu_code_add),
        .rdata_a (cpu_code),
        .raddr_b (ptr_q),
        .rdata_b (host_code)
    );

    post_dual_ram #(
        .Width (1),
        .AddrW (ADDR_W)
    ) u_data_ram (
        .clk     (clk),
        .we      (data_we),
        .waddr   (data_waddr),
        .wdata   (data_wdata),
        .raddr_a (cpu_data_add),
        .rdata_a (cpu_din),
        .raddr_b (ptr_q),
        .rdata_b (host_data)
    );

    // Next-state: host command decode and run supervision
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        timer_d      = timer_q;
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        code_we      = 1'b0;
        host_data_we = 1'b0;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (opcode)
                        CMD_SET_ADDR: state_d = StGetAddr;
                        CMD_WR_CODE: begin
                            code_we = 1'b1;
                            ptr_d   = ptr_q + ADDR_W'(1);
                        end
                        CMD_WR_DATA: begin
                            host_data_we = 1'b1;
                            ptr_d        = ptr_q + ADDR_W'(1);
                        end
                        CMD_RD_DATA: begin
                            out_valid_d = 1'b1;
                            out_byte_d  = {7'b0, host_data};
                            ptr_d       = ptr_q + ADDR_W'(1);
                        end
                        CMD_RD_CODE: begin
                            out_valid_d = 1'b1;
                            out_byte_d  = 8'(host_code);
                            ptr_d       = ptr_q + ADDR_W'(1);
                        end
                        CMD_RUN: state_d = StRunPulse;
                        default: ;
                    endcase
                end
            end
            StGetAddr: begin
                if (accept) begin
                    ptr_d   = ADDR_W'(in_byte);
                    state_d = StIdle;
                end
            end
            StRunPulse: begin
                timer_d = '0;
                state_d = StWaitStart;
            end
            StWaitStart: begin
                timer_d = timer_q + 32'd1;
                if (cpu_state != 8'd0) begin
                    state_d = StWaitStop;
                end else if (timeout) begin
                    state_d = StAbort;
                end
            end
            StWaitStop: begin
                timer_d = timer_q + 32'd1;
                // Stop takes priority over a coincident timeout
                if (cpu_state == 8'd0) begin
                    out_valid_d = 1'b1;
                    out_byte_d  = DONE_BYTE;
                    state_d     = StIdle;
                end else if (timeout) begin
                    state_d = StAbort;
                end
            end
            StAbort: begin
                out_valid_d = 1'b1;
                out_byte_d  = TMO_BYTE;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            timer_q     <= '0;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            timer_q     <= timer_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
        end
    end

endmodule

// File: tb/tb_post_mem_host.sv
// Directed bench for post_mem_host with a tiny behavioural Post CPU.
module tb_post_mem_host;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_byte;
    logic       cpu_run;
    logic       cpu_reset;
    logic [7:0] cpu_state;
    logic [7:0] cpu_code_add;
    logic [3:0] cpu_code;
    logic [7:0] cpu_data_add;
    logic       cpu_din;
    logic       cpu_dout;
    logic       cpu_data_we;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    post_mem_host #(
        .ADDR_W      (8),
        .CODE_W      (4),
        .TIMEOUT_CYC (100),
        .DONE_BYTE   (8'hA5),
        .TMO_BYTE    (8'hEE)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_byte      (in_byte),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_byte     (out_byte),
        .cpu_run      (cpu_run),
        .cpu_reset    (cpu_reset),
        .cpu_state    (cpu_state),
        .cpu_code_add (cpu_code_add),
        .cpu_code     (cpu_code),
        .cpu_data_add (cpu_data_add),
        .cpu_din      (cpu_din),
        .cpu_dout     (cpu_dout),
        .cpu_data_we  (cpu_data_we)
    );

    // Behavioural CPU: 1=incdp, 3=set, 5 hi lo=jmp, 7=stop, others advance
    logic       running;
    logic [7:0] ip, dp;
    logic [1:0] ph;
    logic [3:0] hi;

    assign cpu_state    = {7'b0, running};
    assign cpu_code_add = ip;
    assign cpu_data_add = dp;
    assign cpu_dout     = 1'b1;
    assign cpu_data_we  = running && (ph == 2'd0) && (cpu_code == 4'd3);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            running <= 1'b0; ip <= 8'd0; dp <= 8'd0; ph <= 2'd0; hi <= 4'd0;
        end else if (cpu_reset) begin
            running <= 1'b0; ph <= 2'd0;
        end else if (!running) begin
            if (cpu_run) begin
                running <= 1'b1; ip <= 8'd0; dp <= 8'd0; ph <= 2'd0;
            end
        end else begin
            case (ph)
                2'd0: begin
                    case (cpu_code)
                        4'd1: begin dp <= dp + 8'd1; ip <= ip + 8'd1; end
                        4'd5: begin ph <= 2'd1; ip <= ip + 8'd1; end
                        4'd7: running <= 1'b0;
                        default: ip <= ip + 8'd1;
                    endcase
                end
                2'd1: begin hi <= cpu_code; ip <= ip + 8'd1; ph <= 2'd2; end
                2'd2: begin ip <= {hi, cpu_code}; ph <= 2'd0; end
                default: ph <= 2'd0;
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        in_valid = 1'b1;
        in_byte  = b;
        while (!in_ready && n < 300) begin
            step();
            n++;
        end
        chk("send_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [7:0] exp);
        int n = 0;
        while (!out_valid && n < 300) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk(tag, 32'(out_byte), 32'(exp));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (!cpu_run && n < 20) begin
            step();
            n++;
        end
        chk("run_seen", 32'(cpu_run), 32'd1);
    endtask

    initial begin
        int n;
        int pulses;
        int blk;
        int spur;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_byte   = 8'd0;
        out_ready = 1'b0;

        // Reset values while reset is held
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_byte", 32'(out_byte), 32'd0);
        chk("rst_cpu_run", 32'(cpu_run), 32'd0);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        #19;
        reset_n = 1'b1;
        step();
        chk("idle_in_ready", 32'(in_ready), 32'd1);

        // Code load and readback
        send(8'h10); send(8'h10);
        send(8'h23); send(8'h25);
        send(8'h10); send(8'h10);
        send(8'h50); expect_resp("rd_code0", 8'h03);
        send(8'h50); expect_resp("rd_code1", 8'h05);

        // Pointer wrap: data[0]=0, data[FF]=1 then read FF and the wrapped 00
        send(8'h10); send(8'h00); send(8'h30);
        send(8'h10); send(8'hFF); send(8'h31);
        send(8'h10); send(8'hFF);
        send(8'h40); expect_resp("rd_data_ff", 8'h01);
        send(8'h40); expect_resp("rd_data_wrap", 8'h00);

        // Program {set, incdp, set, stop} on a cleared tape
        send(8'h10); send(8'h00);
        send(8'h23); send(8'h21); send(8'h23); send(8'h27);
        send(8'h10); send(8'h00);
        send(8'h30); send(8'h30); send(8'h30);
        send(8'h60);
        wait_run();
        pulses = 1;
        blk    = 0;
        n      = 0;
        step();
        while (!out_valid && n < 50) begin
            if (cpu_run) pulses++;
            if (in_ready) blk++;
            step();
            n++;
        end
        chk("run_pulses", 32'(pulses), 32'd1);
        chk("run_in_ready_blocked", 32'(blk), 32'd0);
        expect_resp("done_byte", 8'hA5);
        send(8'h10); send(8'h00);
        send(8'h40); expect_resp("tape0", 8'h01);
        send(8'h40); expect_resp("tape1", 8'h01);
        send(8'h40); expect_resp("tape2", 8'h00);

        // Timeout on {jmp 0x00}
        send(8'h10); send(8'h00);
        send(8'h25); send(8'h20); send(8'h20);
        send(8'h60);
        wait_run();
        n = 0;
        while (!cpu_reset && n < 300) begin
            step();
            n++;
        end
        chk("tmo_cycles", 32'(n), 32'd101);
        step();
        chk("tmo_reset_one_cycle", 32'(cpu_reset), 32'd0);
        expect_resp("tmo_byte", 8'hEE);
        chk("tmo_idle", 32'(in_ready), 32'd1);

        // Backpressure: response held, second command waits for handshake
        send(8'h10); send(8'h01);
        send(8'h40);
        in_valid = 1'b1;
        in_byte  = 8'h40;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        chk("bp_first_byte", 32'(out_byte), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_cleared", 32'(out_valid), 32'd0);
        chk("bp_ready_again", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        expect_resp("bp_second_byte", 8'h00);

        // Async reset in WAIT_STOP, program is still the jmp loop
        send(8'h60);
        wait_run();
        for (int i = 0; i < 5; i++) step();
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_byte", 32'(out_byte), 32'd0);
        chk("mid_rst_cpu_run", 32'(cpu_run), 32'd0);
        chk("mid_rst_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        #10;
        reset_n = 1'b1;
        spur = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (out_valid || cpu_reset) spur++;
        end
        chk("post_rst_no_resp", 32'(spur), 32'd0);
        chk("post_rst_idle", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
